// File: rtl/omem_ctrl.sv
// omem_ctrl -- address sequencer and write scheduler for the 64-byte output
// pixel memory (output_mem).
//
// Incoming B/G/R pixels are written into a circular byte buffer of BUF_BYTES
// bytes. The buffer is read back as packed 32-bit words, MSB byte first, and
// each word is offered to the bus-write side with a valid/ready handshake. An
// end-of-frame flush pushes out a final partial word.
//
// output_mem has no write enable. When no pixel is accepted, the write
// addresses are parked on bytes the read side never touches.
//
// Ports
//   I_OCTL_HCLK        clock
//   I_OCTL_HRESET_N    asynchronous active-low reset
//   I_OCTL_PIX_VALID   pixel source offers a B/G/R pixel
//   O_OCTL_PIX_READY   pixel accepted when VALID & READY
//   I_OCTL_FLUSH       one-cycle end-of-frame pulse
//   O_OCTL_IN_ADDRB/G/R  output_mem write addresses (combinational)
//   O_OCTL_OUT_ADDR0..3  output_mem read addresses, WDATA[31:24]..[7:0]
//   O_OCTL_WVALID      output_mem WDATA holds a complete word
//   I_OCTL_WREADY      bus side consumes the word when WVALID & WREADY
//   O_OCTL_WBYTES      valid bytes in the current word (1..4, MSB first)
//   O_OCTL_LAST        current word is the final word of a flush
//   O_OCTL_DONE        one-cycle pulse: flush complete, buffer empty
//   O_OCTL_COUNT       bytes currently occupied in the buffer
module omem_ctrl #(
    parameter int BUF_BYTES = 60,
    parameter int PARK_ADDR = 60
) (
    input  logic       I_OCTL_HCLK,
    input  logic       I_OCTL_HRESET_N,
    input  logic       I_OCTL_PIX_VALID,
    output logic       O_OCTL_PIX_READY,
    input  logic       I_OCTL_FLUSH,
    output logic [7:0] O_OCTL_IN_ADDRB,
    output logic [7:0] O_OCTL_IN_ADDRG,
    output logic [7:0] O_OCTL_IN_ADDRR,
    output logic [7:0] O_OCTL_OUT_ADDR0,
    output logic [7:0] O_OCTL_OUT_ADDR1,
    output logic [7:0] O_OCTL_OUT_ADDR2,
    output logic [7:0] O_OCTL_OUT_ADDR3,
    output logic       O_OCTL_WVALID,
    input  logic       I_OCTL_WREADY,
    output logic [2:0] O_OCTL_WBYTES,
    output logic       O_OCTL_LAST,
    output logic       O_OCTL_DONE,
    output logic [6:0] O_OCTL_COUNT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_PIPE,
        S_VALID
    } state_t;

    localparam logic [8:0] BUF9  = 9'(BUF_BYTES);
    localparam logic [6:0] BUF7  = 7'(BUF_BYTES);
    localparam logic [7:0] PARK8 = 8'(PARK_ADDR);

    state_t     state;
    logic [7:0] wr_ptr;
    logic [7:0] rd_ptr;
    logic [6:0] count;
    logic       flush_pend;

    logic       accept;
    logic       hs;
    logic       drain;
    logic       flush_empty;
    logic       issue;
    logic [2:0] issue_bytes;
    logic [6:0] count_next;

    // Pointer add with wrap at BUF_BYTES; operands never exceed one wrap.
    function automatic logic [7:0] wrap_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= BUF9)
            s = s - BUF9;
        return s[7:0];
    endfunction

    // Held low while reset is asserted even though count is already 0.
    assign O_OCTL_PIX_READY = I_OCTL_HRESET_N && !flush_pend && ((BUF7 - count) >= 7'd3);
    assign accept           = I_OCTL_PIX_VALID && O_OCTL_PIX_READY;
    assign hs               = O_OCTL_WVALID && I_OCTL_WREADY;

    // wr_ptr is always a multiple of 3 below BUF_BYTES, so +1/+2 never wrap.
    assign O_OCTL_IN_ADDRB = accept ? wr_ptr         : PARK8;
    assign O_OCTL_IN_ADDRG = accept ? wr_ptr + 8'd1  : PARK8 + 8'd1;
    assign O_OCTL_IN_ADDRR = accept ? wr_ptr + 8'd2  : PARK8 + 8'd2;

    assign O_OCTL_COUNT = count;

    // Once a flush is pending no more pixels enter, so the word whose size
    // equals the remaining occupancy is the one that empties the buffer.
    assign O_OCTL_LAST = O_OCTL_WVALID && flush_pend && (count == {4'd0, O_OCTL_WBYTES});
    assign drain       = hs && O_OCTL_LAST;

    assign count_next = count + (accept ? 7'd3 : 7'd0) - (hs ? {4'd0, O_OCTL_WBYTES} : 7'd0);

    // A flush that finds the buffer empty (including one emptied by a
    // handshake in the same cycle) completes immediately.
    assign flush_empty = I_OCTL_FLUSH && !flush_pend && (count_next == 7'd0);

    assign issue       = (count >= 7'd4) || (flush_pend && (count != 7'd0));
    assign issue_bytes = (count >= 7'd4) ? 3'd4 : count[2:0];

    always_ff @(posedge I_OCTL_HCLK or negedge I_OCTL_HRESET_N) begin
        if (!I_OCTL_HRESET_N) begin
            state            <= S_IDLE;
            wr_ptr           <= 8'd0;
            rd_ptr           <= 8'd0;
            count            <= 7'd0;
            flush_pend       <= 1'b0;
            O_OCTL_OUT_ADDR0 <= 8'd0;
            O_OCTL_OUT_ADDR1 <= 8'd0;
            O_OCTL_OUT_ADDR2 <= 8'd0;
            O_OCTL_OUT_ADDR3 <= 8'd0;
            O_OCTL_WVALID    <= 1'b0;
            O_OCTL_WBYTES    <= 3'd4;
            O_OCTL_DONE      <= 1'b0;
        end else begin
            O_OCTL_DONE <= 1'b0;

            // ADDR and PIPE cover output_mem's two-register read latency.
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        state            <= S_ADDR;
                        O_OCTL_OUT_ADDR0 <= rd_ptr;
                        O_OCTL_OUT_ADDR1 <= wrap_add(rd_ptr, 8'd1);
                        O_OCTL_OUT_ADDR2 <= wrap_add(rd_ptr, 8'd2);
                        O_OCTL_OUT_ADDR3 <= wrap_add(rd_ptr, 8'd3);
                        O_OCTL_WBYTES    <= issue_bytes;
                    end
                end
                S_ADDR: state <= S_PIPE;
                S_PIPE: begin
                    state         <= S_VALID;
                    O_OCTL_WVALID <= 1'b1;
                end
                S_VALID: begin
                    if (I_OCTL_WREADY) begin
                        state         <= S_IDLE;
                        O_OCTL_WVALID <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (drain || flush_empty) begin
                // Frame finished: restart the buffer from byte 0.
                wr_ptr      <= 8'd0;
                rd_ptr      <= 8'd0;
                count       <= 7'd0;
                flush_pend  <= 1'b0;
                O_OCTL_DONE <= 1'b1;
            end else begin
                count <= count_next;
                if (accept)
                    wr_ptr <= wrap_add(wr_ptr, 8'd3);
                if (hs)
                    rd_ptr <= wrap_add(rd_ptr, {5'd0, O_OCTL_WBYTES});
                if (I_OCTL_FLUSH)
                    flush_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_omem_ctrl.sv
// Testbench for omem_ctrl. Models output_mem (write every cycle, two-register
// read) and keeps a byte-queue reference of the buffer contents.
module tb_omem_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_valid = 1'b0;
    logic       flush = 1'b0;
    logic       wready = 1'b0;
    logic [7:0] pix_b = 8'd0, pix_g = 8'd0, pix_r = 8'd0;

    logic       pix_ready, wvalid, last, done;
    logic [7:0] in_addrb, in_addrg, in_addrr;
    logic [7:0] out_addr0, out_addr1, out_addr2, out_addr3;
    logic [2:0] wbytes;
    logic [6:0] count;

    omem_ctrl dut (
        .I_OCTL_HCLK      (clk),
        .I_OCTL_HRESET_N  (rst_n),
        .I_OCTL_PIX_VALID (pix_valid),
        .O_OCTL_PIX_READY (pix_ready),
        .I_OCTL_FLUSH     (flush),
        .O_OCTL_IN_ADDRB  (in_addrb),
        .O_OCTL_IN_ADDRG  (in_addrg),
        .O_OCTL_IN_ADDRR  (in_addrr),
        .O_OCTL_OUT_ADDR0 (out_addr0),
        .O_OCTL_OUT_ADDR1 (out_addr1),
        .O_OCTL_OUT_ADDR2 (out_addr2),
        .O_OCTL_OUT_ADDR3 (out_addr3),
        .O_OCTL_WVALID    (wvalid),
        .I_OCTL_WREADY    (wready),
        .O_OCTL_WBYTES    (wbytes),
        .O_OCTL_LAST      (last),
        .O_OCTL_DONE      (done),
        .O_OCTL_COUNT     (count)
    );

    always #5 clk = ~clk;

    // output_mem model: unconditional byte writes, address then data register on read.
    logic [7:0] mem [0:255];
    logic [7:0] a1 [4];
    logic [7:0] rdat [4];
    always @(posedge clk) begin
        mem[in_addrb] <= pix_b;
        mem[in_addrg] <= pix_g;
        mem[in_addrr] <= pix_r;
        a1[0] <= out_addr0; a1[1] <= out_addr1; a1[2] <= out_addr2; a1[3] <= out_addr3;
        for (int k = 0; k < 4; k++) rdat[k] <= mem[a1[k]];
    end

    int n_chk = 0, n_fail = 0, cyc = 0;

    // Reference model: buffer as a FIFO of bytes plus the two pointers.
    logic [7:0] q[$];
    int  m_wr, m_rd;
    bit  m_fp, m_done;

    // Per-cycle observation and expectation snapshot.
    logic       o_ready, o_wvalid, o_last, o_done;
    logic [7:0] o_ab, o_ag, o_ar;
    logic [6:0] o_count;
    logic [2:0] o_wbytes;
    logic [7:0] o_oa [4], o_wd [4];
    logic       e_ready, e_last, e_done;
    logic [7:0] e_ab, e_ag, e_ar;
    logic [6:0] e_count;
    logic [2:0] e_wb;
    logic [7:0] e_oa [4], e_wd [4];

    task automatic model_reset();
        q.delete(); m_wr = 0; m_rd = 0; m_fp = 0; m_done = 0;
    endtask

    // Drive one cycle, snapshot outputs before the edge, advance the model.
    task automatic cycle(input bit v, input bit f, input bit wr);
        int  nb;
        bit  acc, hs;
        pix_valid = v; flush = f; wready = wr;
        pix_b = 8'($urandom); pix_g = 8'($urandom); pix_r = 8'($urandom);
        #1;
        o_ready = pix_ready; o_wvalid = wvalid; o_last = last; o_done = done;
        o_ab = in_addrb; o_ag = in_addrg; o_ar = in_addrr;
        o_count = count; o_wbytes = wbytes;
        o_oa[0] = out_addr0; o_oa[1] = out_addr1; o_oa[2] = out_addr2; o_oa[3] = out_addr3;
        for (int k = 0; k < 4; k++) o_wd[k] = rdat[k];

        e_ready = !m_fp && (60 - q.size() >= 3);
        acc     = v && e_ready;
        e_ab    = acc ? 8'(m_wr) : 8'd60;
        e_ag    = e_ab + 8'd1;
        e_ar    = e_ab + 8'd2;
        e_count = 7'(q.size());
        e_done  = m_done;
        nb      = (q.size() < 4) ? q.size() : 4;
        e_wb    = 3'(nb);
        e_last  = m_fp && (q.size() == nb) && (nb > 0);
        for (int k = 0; k < 4; k++) begin
            e_oa[k] = 8'((m_rd + k) % 60);
            e_wd[k] = (k < q.size()) ? q[k] : 8'h00;
        end
        hs = o_wvalid && wr && (nb > 0);

        @(posedge clk);
        cyc++;
        m_done = 0;
        if (hs) begin
            for (int k = 0; k < nb; k++) void'(q.pop_front());
            m_rd = (m_rd + nb) % 60;
        end
        if (acc) begin
            q.push_back(pix_b); q.push_back(pix_g); q.push_back(pix_r);
            m_wr = (m_wr + 3) % 60;
        end
        if (hs && m_fp && q.size() == 0) begin
            m_done = 1; m_fp = 0; m_wr = 0; m_rd = 0;
        end else if (f && !m_fp) begin
            if (q.size() == 0) begin m_done = 1; m_wr = 0; m_rd = 0; end
            else m_fp = 1;
        end
        @(negedge clk);
    endtask

    task automatic drain(input bit with_flush, input int maxc, output bit ok);
        ok = 0;
        cycle(0, with_flush, 1);
        for (int i = 0; i < maxc; i++) begin
            if (q.size() == 0 && !m_fp) begin ok = 1; break; end
            cycle(0, 0, 1);
        end
        cycle(0, 0, 1);
        cycle(0, 0, 1);
    endtask

    task automatic test_reset();
        #12;
        n_chk++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", pix_ready); end
        n_chk++; if (wvalid !== 1'b0 || last !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %b%b%b exp 000", wvalid, last, done); end
        n_chk++; if (wbytes !== 3'd4) begin n_fail++; $display("FAIL reset_wbytes got %0d exp 4", wbytes); end
        n_chk++; if (count !== 7'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_chk++; if ({out_addr0, out_addr1, out_addr2, out_addr3} !== 32'd0) begin n_fail++; $display("FAIL reset_oaddr got %h exp 0", {out_addr0, out_addr1, out_addr2, out_addr3}); end
        n_chk++; if ({in_addrb, in_addrg, in_addrr} !== {8'd60, 8'd61, 8'd62}) begin n_fail++; $display("FAIL reset_park got %0d/%0d/%0d exp 60/61/62", in_addrb, in_addrg, in_addrr); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_words();
        int got[$];
        for (int i = 0; i < 34; i++) begin
            cycle(i < 4, 0, 1);
            n_chk++; if (o_ab !== e_ab) begin n_fail++; $display("FAIL words_inaddr cyc=%0d got %0d exp %0d", cyc, o_ab, e_ab); end
            if (o_wvalid) begin
                got.push_back(int'(o_oa[0]));
                n_chk++; if (o_wbytes !== 3'd4) begin n_fail++; $display("FAIL words_wbytes got %0d exp 4", o_wbytes); end
                n_chk++; if ({o_wd[0], o_wd[1], o_wd[2], o_wd[3]} !== {e_wd[0], e_wd[1], e_wd[2], e_wd[3]}) begin n_fail++; $display("FAIL words_data got %h exp %h", {o_wd[0], o_wd[1], o_wd[2], o_wd[3]}, {e_wd[0], e_wd[1], e_wd[2], e_wd[3]}); end
            end
        end
        n_chk++; if (got.size() != 3) begin n_fail++; $display("FAIL words_num got %0d exp 3", got.size()); end
        else for (int k = 0; k < 3; k++) begin
            n_chk++; if (got[k] != 4 * k) begin n_fail++; $display("FAIL words_addr%0d got %0d exp %0d", k, got[k], 4 * k); end
        end
        n_chk++; if (o_count !== 7'd0) begin n_fail++; $display("FAIL words_count got %0d exp 0", o_count); end
    endtask

    task automatic test_flush();
        int wbq[$], lastq[$];
        int n_done = 0, hs_idx = -1, done_idx = -2;
        int exp_wb[4] = '{4, 4, 4, 3};
        for (int i = 0; i < 60; i++) begin
            cycle(i < 5, i == 5, 1);
            n_chk++; if (o_done !== e_done) begin n_fail++; $display("FAIL flush_done cyc=%0d got %b exp %b", cyc, o_done, e_done); end
            if (o_done) begin n_done++; done_idx = i; end
            if (o_wvalid) begin
                wbq.push_back(int'(o_wbytes)); lastq.push_back(int'(o_last)); hs_idx = i;
                n_chk++; if (o_oa[0] !== e_oa[0]) begin n_fail++; $display("FAIL flush_oaddr got %0d exp %0d", o_oa[0], e_oa[0]); end
                for (int k = 0; k < 4; k++) if (k < int'(e_wb)) begin
                    n_chk++; if (o_wd[k] !== e_wd[k]) begin n_fail++; $display("FAIL flush_data%0d got %h exp %h", k, o_wd[k], e_wd[k]); end
                end
            end
        end
        n_chk++; if (wbq.size() != 4) begin n_fail++; $display("FAIL flush_words got %0d exp 4", wbq.size()); end
        else for (int k = 0; k < 4; k++) begin
            n_chk++; if (wbq[k] != exp_wb[k] || lastq[k] != (k == 3 ? 1 : 0)) begin n_fail++; $display("FAIL flush_word%0d got wb=%0d last=%0d exp wb=%0d last=%0d", k, wbq[k], lastq[k], exp_wb[k], k == 3); end
        end
        n_chk++; if (n_done != 1 || done_idx != hs_idx + 1) begin n_fail++; $display("FAIL flush_done_pulse got n=%0d at %0d exp 1 at %0d", n_done, done_idx, hs_idx + 1); end
        n_chk++; if (o_count !== 7'd0) begin n_fail++; $display("FAIL flush_count got %0d exp 0", o_count); end
    endtask

    // Two pixels from an empty buffer, WREADY held low: WVALID appears three
    // cycles after the IDLE exit edge and then waits.
    task automatic test_latency();
        cycle(1, 0, 0);
        n_chk++; if (o_ab !== 8'd0) begin n_fail++; $display("FAIL lat_first_addr got %0d exp 0", o_ab); end
        cycle(1, 0, 0);
        for (int i = 3; i <= 6; i++) begin
            cycle(0, 0, 0);
            n_chk++; if (o_wvalid !== (i == 6)) begin n_fail++; $display("FAIL lat_wvalid c%0d got %b exp %b", i, o_wvalid, i == 6); end
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (wvalid !== 1'b0) begin n_fail++; $display("FAIL areset_wvalid got %b exp 0", wvalid); end
        n_chk++; if (count !== 7'd0 || wbytes !== 3'd4 || last !== 1'b0 || done !== 1'b0 || pix_ready !== 1'b0) begin n_fail++; $display("FAIL areset_outs got cnt=%0d wb=%0d l=%b d=%b r=%b exp 0/4/0/0/0", count, wbytes, last, done, pix_ready); end
        n_chk++; if ({out_addr0, out_addr1, out_addr2, out_addr3} !== 32'd0) begin n_fail++; $display("FAIL areset_oaddr got %h exp 0", {out_addr0, out_addr1, out_addr2, out_addr3}); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle(1, 0, 1);
        n_chk++; if (o_ab !== 8'd0 || o_count !== 7'd0) begin n_fail++; $display("FAIL areset_restart got addr=%0d cnt=%0d exp 0/0", o_ab, o_count); end
        drain(1, 40, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL areset_drain got timeout exp drained"); end
    endtask

    task automatic test_full();
        int n_acc = 0;
        bit ok;
        for (int i = 0; i < 26; i++) begin
            cycle(1, 0, 0);
            n_chk++; if (o_ready !== e_ready) begin n_fail++; $display("FAIL full_ready cyc=%0d got %b exp %b", cyc, o_ready, e_ready); end
            if (o_ready) n_acc++;
        end
        n_chk++; if (n_acc != 20) begin n_fail++; $display("FAIL full_accepts got %0d exp 20", n_acc); end
        cycle(1, 0, 0);
        n_chk++; if (o_count !== 7'd60 || o_ready !== 1'b0) begin n_fail++; $display("FAIL full_state got cnt=%0d rdy=%b exp 60/0", o_count, o_ready); end
        n_chk++; if ({o_ab, o_ag, o_ar} !== {8'd60, 8'd61, 8'd62}) begin n_fail++; $display("FAIL full_park got %0d/%0d/%0d exp 60/61/62", o_ab, o_ag, o_ar); end
        drain(0, 150, ok);
        n_chk++; if (!ok || o_count !== 7'd0) begin n_fail++; $display("FAIL full_drain got ok=%b cnt=%0d exp 1/0", ok, o_count); end
    endtask

    task automatic test_wrap();
        int n_acc = 0, prev_ab = -1, prev_oa = -1;
        bit saw_wr = 0, saw_rd = 0, ok;
        for (int i = 0; i < 400 && n_acc < 45; i++) begin
            cycle(1, 0, 1);
            if (o_ready) begin
                if (prev_ab == 57) begin
                    saw_wr = 1;
                    n_chk++; if (o_ab !== 8'd0) begin n_fail++; $display("FAIL wrap_wr got %0d exp 0", o_ab); end
                end
                prev_ab = int'(o_ab);
                n_acc++;
            end
            if (o_wvalid) begin
                if (prev_oa == 56) begin
                    saw_rd = 1;
                    n_chk++; if ({o_oa[0], o_oa[1], o_oa[2], o_oa[3]} !== {8'd0, 8'd1, 8'd2, 8'd3}) begin n_fail++; $display("FAIL wrap_rd got %0d-%0d exp 0-3", o_oa[0], o_oa[3]); end
                end
                prev_oa = int'(o_oa[0]);
                n_chk++; if ({o_wd[0], o_wd[1], o_wd[2], o_wd[3]} !== {e_wd[0], e_wd[1], e_wd[2], e_wd[3]}) begin n_fail++; $display("FAIL wrap_data got %h exp %h", {o_wd[0], o_wd[1], o_wd[2], o_wd[3]}, {e_wd[0], e_wd[1], e_wd[2], e_wd[3]}); end
            end
        end
        n_chk++; if (n_acc != 45 || !saw_wr || !saw_rd) begin n_fail++; $display("FAIL wrap_seen got acc=%0d wr=%b rd=%b exp 45/1/1", n_acc, saw_wr, saw_rd); end
        drain(1, 150, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL wrap_drain got timeout exp drained"); end
    endtask

    task automatic test_back_to_back();
        bit ok, seen;
        for (int i = 0; i < 3; i++) cycle(1, 0, 0);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin cycle(0, 0, 0); seen = o_wvalid; end
        cycle(0, 0, 1);
        cycle(1, 0, 0);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin cycle(0, 0, 0); seen = o_wvalid; end
        n_chk++; if (!seen) begin n_fail++; $display("FAIL b2b_wvalid got timeout exp word"); end
        cycle(1, 0, 1);
        n_chk++; if (o_count !== 7'd8 || !o_wvalid || !o_ready) begin n_fail++; $display("FAIL b2b_pre got cnt=%0d v=%b r=%b exp 8/1/1", o_count, o_wvalid, o_ready); end
        cycle(0, 0, 0);
        n_chk++; if (o_count !== 7'd7) begin n_fail++; $display("FAIL b2b_count got %0d exp 7", o_count); end
        drain(1, 60, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL b2b_drain got timeout exp drained"); end
        cycle(0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0);
            n_chk++; if (o_done !== (i == 0) || o_wvalid !== 1'b0) begin n_fail++; $display("FAIL empty_flush c%0d got d=%b v=%b exp %b/0", i, o_done, o_wvalid, i == 0); end
        end
    endtask

    task automatic test_random();
        bit v, f, w, ok;
        for (int i = 0; i < 800; i++) begin
            v = ($urandom_range(0, 9) < 7);
            w = ($urandom_range(0, 9) < 6);
            f = !m_fp && (q.size() > 4) && ($urandom_range(0, 39) == 0);
            cycle(v, f, w);
            n_chk++; if (o_ready !== e_ready) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got %b exp %b", cyc, o_ready, e_ready); end
            n_chk++; if ({o_ab, o_ag, o_ar} !== {e_ab, e_ag, e_ar}) begin n_fail++; $display("FAIL rnd_inaddr cyc=%0d got %0d exp %0d", cyc, o_ab, e_ab); end
            n_chk++; if (o_count !== e_count) begin n_fail++; $display("FAIL rnd_count cyc=%0d got %0d exp %0d", cyc, o_count, e_count); end
            n_chk++; if (o_done !== e_done) begin n_fail++; $display("FAIL rnd_done cyc=%0d got %b exp %b", cyc, o_done, e_done); end
            if (o_wvalid) begin
                n_chk++; if (o_wbytes !== e_wb || o_last !== e_last) begin n_fail++; $display("FAIL rnd_word cyc=%0d got wb=%0d l=%b exp wb=%0d l=%b", cyc, o_wbytes, o_last, e_wb, e_last); end
                for (int k = 0; k < 4; k++) begin
                    n_chk++; if (o_oa[k] !== e_oa[k]) begin n_fail++; $display("FAIL rnd_oaddr%0d cyc=%0d got %0d exp %0d", k, cyc, o_oa[k], e_oa[k]); end
                    if (k < int'(e_wb)) begin
                        n_chk++; if (o_wd[k] !== e_wd[k]) begin n_fail++; $display("FAIL rnd_data%0d cyc=%0d got %h exp %h", k, cyc, o_wd[k], e_wd[k]); end
                    end
                end
            end
        end
        drain(1, 200, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL rnd_drain got timeout exp drained"); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_words();
        test_flush();
        test_latency();
        test_async_reset();
        test_full();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
